half_channel_fifo: RTL and testbench



---
 rtl/half_channel_fifo_if.sv | 22 ++
 rtl/half_channel_fifo.sv | 82 ++++++++
 tb/tb_half_channel_fifo.sv | 197 +++++++++++++++++++
 3 files changed

// File: rtl/half_channel_fifo_if.sv
// HalfChannel (valid/data, no backpressure) and Channel (valid/data/acknowledge) interfaces
// used at the ports of half_channel_fifo.
interface half_channel_if #(
    parameter int N = 8
);
    logic [N-1:0] d;
    logic         v;

    modport src (output d, output v);
    modport snk (input d, input v);
endinterface

interface channel_if #(
    parameter int N = 8
);
    logic [N-1:0] d;
    logic         v;
    logic         a;

    modport src (output d, output v, input a);
    modport snk (input d, input v, output a);
endinterface

// File: rtl/half_channel_fifo.sv
// Buffers a free-running HalfChannel into a handshaked Channel; words arriving when full are
// dropped and counted. Optional high-water mark output enabled by HALF_CHANNEL_FIFO_HWM_EN.
module half_channel_fifo #(
    parameter int N      = 8,
    parameter int Depth  = 16,
    parameter int CountW = 16
) (
    input  logic                    clk,
    input  logic                    reset_n,
    half_channel_if.snk             in,
    channel_if.src                  out,
    output logic [$clog2(Depth):0]  occupancy,
    output logic [CountW-1:0]       drop_count,
    output logic                    overflow
`ifdef HALF_CHANNEL_FIFO_HWM_EN
    ,
    output logic [$clog2(Depth):0]  high_water
`endif
);
    localparam int AW = $clog2(Depth);
    localparam int OW = AW + 1;

    // Handshake: a word moves to the sink at a posedge where out.v and out.a are both 1;
    // the upstream side has no ready and simply loses words presented while the buffer is full.
    logic [N-1:0]  mem [Depth];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          valid_q;
    logic          full;
    logic          pop;
    logic          push;
    logic          drop;
    logic [OW-1:0] occ_next;

    always_comb begin
        full     = (occupancy == OW'(Depth));
        pop      = valid_q && out.a;
        // A pop in the same cycle frees the slot, so a full FIFO can still accept.
        push     = in.v && (!full || pop);
        drop     = in.v && full && !pop;
        occ_next = occupancy + OW'(push) - OW'(pop);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            occupancy  <= '0;
            valid_q    <= 1'b0;
            drop_count <= '0;
            overflow   <= 1'b0;
        end else begin
            occupancy <= occ_next;
            valid_q   <= (occ_next != '0);
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            if (drop) begin
                overflow <= 1'b1;
                if (drop_count != '1) drop_count <= drop_count + CountW'(1);
            end
        end
    end

    // Storage needs no reset: contents are unreachable until rewritten.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= in.d;
    end

    assign out.v = valid_q;
    assign out.d = mem[rd_ptr];

`ifdef HALF_CHANNEL_FIFO_HWM_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            high_water <= '0;
        end else if (occ_next > high_water) begin
            high_water <= occ_next;
        end
    end
`endif

endmodule

// File: tb/tb_half_channel_fifo.sv
// Directed and randomized checks of half_channel_fifo against a queue-based reference model.
module tb_half_channel_fifo;
    localparam int N     = 8;
    localparam int DEPTH = 16;
    localparam int OW    = 5;
    localparam int CW    = 16;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    always #5 clk = ~clk;

    half_channel_if #(.N(N)) in_if ();
    channel_if      #(.N(N)) out_if ();

    logic [OW-1:0] occupancy;
    logic [CW-1:0] drop_count;
    logic          overflow;
`ifdef HALF_CHANNEL_FIFO_HWM_EN
    logic [OW-1:0] high_water;
`endif

    half_channel_fifo #(.N(N), .Depth(DEPTH), .CountW(CW)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .in         (in_if),
        .out        (out_if),
        .occupancy  (occupancy),
        .drop_count (drop_count),
        .overflow   (overflow)
`ifdef HALF_CHANNEL_FIFO_HWM_EN
        ,
        .high_water (high_water)
`endif
    );

    int errors = 0;
    int checks = 0;

    // Reference model: contents as a queue, plus drop counter, sticky flag and peak size.
    logic [N-1:0] exp_q[$];
    int           m_drop = 0;
    bit           m_ovf  = 1'b0;
    int           m_peak = 0;
    logic [N-1:0] got_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        exp_q.delete();
        m_drop = 0;
        m_ovf  = 1'b0;
        m_peak = 0;
    endtask

    task automatic check_outputs();
        chk("out_v", 32'(out_if.v), 32'(exp_q.size() != 0));
        if (exp_q.size() != 0) chk("out_d", 32'(out_if.d), 32'(exp_q[0]));
        chk("occupancy", 32'(occupancy), 32'(exp_q.size()));
        chk("drop_count", 32'(drop_count), 32'(m_drop));
        chk("overflow", 32'(overflow), 32'(m_ovf));
`ifdef HALF_CHANNEL_FIFO_HWM_EN
        chk("high_water", 32'(high_water), 32'(m_peak));
`endif
    endtask

    // One clock cycle, entered and left at a negedge.
    task automatic step(input logic v, input logic [N-1:0] d, input logic a);
        in_if.v  = v;
        in_if.d  = d;
        out_if.a = a;
        #1;
        check_outputs();
        if (out_if.v && a) got_q.push_back(out_if.d);
        if (exp_q.size() != 0 && a) void'(exp_q.pop_front());
        if (v) begin
            if (exp_q.size() < DEPTH) begin
                exp_q.push_back(d);
            end else begin
                if (m_drop < (1 << CW) - 1) m_drop++;
                m_ovf = 1'b1;
            end
        end
        if (exp_q.size() > m_peak) m_peak = exp_q.size();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        int sent;
        int wait_cnt;
        logic v;
        logic a;

        // Reset with the source active: nothing may be stored or presented.
        in_if.v  = 1'b1;
        in_if.d  = 8'h3C;
        out_if.a = 1'b1;
        model_reset();
        repeat (3) begin
            @(negedge clk);
            check_outputs();
        end
        reset_n = 1'b1;
        repeat (3) step(1'b0, 8'h00, 1'b1);

        // Single word held under backpressure, then one transfer.
        got_q.delete();
        step(1'b1, 8'hA5, 1'b0);
        repeat (4) step(1'b0, 8'h00, 1'b0);
        repeat (3) step(1'b0, 8'h00, 1'b1);
        chk("single_xfer_count", 32'(got_q.size()), 32'd1);
        if (got_q.size() == 1) chk("single_xfer_data", 32'(got_q[0]), 32'hA5);

        // Streaming at full rate.
        got_q.delete();
        for (int i = 0; i < 100; i++) begin
            step(1'b1, 8'(i), 1'b1);
            chk("stream_occ_le1", 32'(occupancy <= 1), 32'd1);
        end
        repeat (2) step(1'b0, 8'h00, 1'b1);
        chk("stream_count", 32'(got_q.size()), 32'd100);
        for (int i = 0; i < 100 && i < got_q.size(); i++) chk("stream_order", 32'(got_q[i]), 32'(i));

        // Overflow: 20 words into 16 slots with no sink.
        got_q.delete();
        for (int i = 0; i < 20; i++) step(1'b1, 8'(i), 1'b0);
        chk("ovf_occupancy", 32'(occupancy), 32'd16);
        chk("ovf_drop_count", 32'(drop_count), 32'd4);
        chk("ovf_flag", 32'(overflow), 32'd1);
        repeat (18) step(1'b0, 8'h00, 1'b1);
        chk("ovf_drain_count", 32'(got_q.size()), 32'd16);
        for (int i = 0; i < 16 && i < got_q.size(); i++) chk("ovf_drain_order", 32'(got_q[i]), 32'(i));
        chk("ovf_sticky", 32'(overflow), 32'd1);

        // Full plus simultaneous push and pop.
        got_q.delete();
        for (int i = 0; i < 16; i++) step(1'b1, 8'(8'h40 + i), 1'b0);
        chk("full_occupancy", 32'(occupancy), 32'd16);
        step(1'b1, 8'h77, 1'b1);
        chk("full_pushpop_occ", 32'(occupancy), 32'd16);
        chk("full_pushpop_drop", 32'(drop_count), 32'd4);
        repeat (18) step(1'b0, 8'h00, 1'b1);
        chk("full_drain_count", 32'(got_q.size()), 32'd17);
        if (got_q.size() == 17) chk("full_last_word", 32'(got_q[16]), 32'h77);

        // Asynchronous reset between clock edges with words stored.
        for (int i = 0; i < 6; i++) step(1'b1, 8'(8'hC0 + i), 1'b0);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_rst_out_v", 32'(out_if.v), 32'd0);
        chk("async_rst_occ", 32'(occupancy), 32'd0);
        chk("async_rst_drop", 32'(drop_count), 32'd0);
        chk("async_rst_ovf", 32'(overflow), 32'd0);
        model_reset();
        @(posedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        got_q.delete();
        repeat (3) step(1'b0, 8'h00, 1'b1);
        chk("after_rst_no_output", 32'(got_q.size()), 32'd0);

        // Random bursty source against a sink with 0..5 cycle gaps.
        got_q.delete();
        sent = 0;
        wait_cnt = 0;
        while (sent < 10000) begin
            v = ($urandom_range(0, 3) != 0);
            a = (wait_cnt == 0);
            if (a && exp_q.size() != 0) wait_cnt = $urandom_range(0, 5);
            else if (wait_cnt > 0) wait_cnt--;
            step(v, 8'($urandom), a);
            if (v) sent++;
        end
        repeat (DEPTH + 2) step(1'b0, 8'h00, 1'b1);
        chk("rnd_accepted_plus_dropped", 32'(got_q.size()) + 32'(drop_count), 32'd10000);
        chk("rnd_drained", 32'(occupancy), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #5_000_000;
        errors++;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "simulation time limit reached");
    end

endmodule
